// File: rtl/dnn_mmap_pkg.sv
// dnn_mmap_pkg: register map and FSM state shared by the DNN register master and slave
package dnn_mmap_pkg;
    localparam logic [31:0] READ_FINISH         = 32'h00;
    localparam logic [31:0] WRITE_CONV          = 32'h04;
    localparam logic [31:0] WRITE_N             = 32'h08;
    localparam logic [31:0] WRITE_C             = 32'h0C;
    localparam logic [31:0] WRITE_H             = 32'h10;
    localparam logic [31:0] WRITE_W             = 32'h14;
    localparam logic [31:0] WRITE_R             = 32'h18;
    localparam logic [31:0] WRITE_S             = 32'h1C;
    localparam logic [31:0] WRITE_M             = 32'h20;
    localparam logic [31:0] WRITE_P             = 32'h24;
    localparam logic [31:0] WRITE_Q             = 32'h28;
    localparam logic [31:0] WRITE_INPUT_OFFSET  = 32'h2C;
    localparam logic [31:0] WRITE_WEIGHT_OFFSET = 32'h30;
    localparam logic [31:0] WRITE_OUTPUT_OFFSET = 32'h34;
    localparam logic [31:0] WRITE_START         = 32'h38;
    localparam int NUM_CFG_WRITES = 14;
    localparam logic [NUM_CFG_WRITES*32-1:0] CFG_OFFS = {
        WRITE_CONV, WRITE_N, WRITE_C, WRITE_H, WRITE_W, WRITE_R, WRITE_S,
        WRITE_M, WRITE_P, WRITE_Q, WRITE_INPUT_OFFSET, WRITE_WEIGHT_OFFSET,
        WRITE_OUTPUT_OFFSET, WRITE_START};
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WGAP, S_POLL, S_PGAP} state_t;
endpackage

// File: rtl/dnn_mmap_master.sv
// dnn_mmap_master: programs one conv job into the DNN register slave, then polls FINISH
module dnn_mmap_master
    import dnn_mmap_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic         job_conv,
    input  logic [287:0] job_dims,
    input  logic [95:0]  job_offs,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         mem_valid,
    output logic [31:0]  mem_addr,
    output logic [3:0]   mem_wstrb,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ready
);
    localparam int GAP = POLL_GAP < 1 ? 1 : POLL_GAP;
    state_t state;
    logic [3:0] k;
    logic [31:0] gcnt;
    logic [TO_W-1:0] tcnt;
    logic conv_q;
    logic [287:0] dims_q;
    logic [95:0] offs_q;
    logic fin, tout, unused_rdata;

    function automatic logic [31:0] cfg_word(input logic [447:0] tbl, input logic [3:0] idx);
        return tbl[32*(13-int'(idx)) +: 32];
    endfunction

    assign job_ready = state == S_IDLE;
    assign fin = state == S_POLL && mem_valid && mem_ready && mem_rdata[0];
    assign tout = TIMEOUT != 0 && tcnt == TO_W'(TIMEOUT) && (state == S_POLL || state == S_PGAP);
    assign unused_rdata = ^mem_rdata[31:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            mem_valid <= 1'b0;
            mem_addr <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            k <= '0;
            gcnt <= '0;
            tcnt <= '0;
            conv_q <= 1'b0;
            dims_q <= '0;
            offs_q <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            if (state == S_POLL || state == S_PGAP) tcnt <= tcnt + TO_W'(1);
            case (state)
                S_IDLE: if (job_valid) begin
                    conv_q <= job_conv;
                    dims_q <= job_dims;
                    offs_q <= job_offs;
                    busy <= 1'b1;
                    k <= '0;
                    mem_valid <= 1'b1;
                    mem_addr <= BASE_ADDR + WRITE_CONV;
                    mem_wstrb <= 4'hF;
                    mem_wdata <= {31'b0, job_conv};
                    state <= S_WR;
                end
                S_WR: if (mem_ready) begin
                    mem_valid <= 1'b0;
                    k <= k + 4'd1;
                    state <= S_WGAP;
                end
                S_WGAP: begin
                    mem_valid <= 1'b1;
                    if (k == 4'(NUM_CFG_WRITES)) begin
                        mem_addr <= BASE_ADDR + READ_FINISH;
                        mem_wstrb <= 4'h0;
                        mem_wdata <= '0;
                        tcnt <= '0;
                        state <= S_POLL;
                    end else begin
                        mem_addr <= BASE_ADDR + cfg_word(CFG_OFFS, k);
                        mem_wdata <= cfg_word({31'b0, conv_q, dims_q, offs_q, 32'd1}, k);
                        state <= S_WR;
                    end
                end
                S_POLL: if (fin || tout) begin
                    done <= fin;
                    err <= !fin;
                    busy <= 1'b0;
                    mem_valid <= 1'b0;
                    state <= S_IDLE;
                end else if (mem_ready) begin
                    mem_valid <= 1'b0;
                    gcnt <= 32'(GAP - 1);
                    state <= S_PGAP;
                end
                S_PGAP: if (tout) begin
                    err <= 1'b1;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end else if (gcnt == 32'd0) begin
                    mem_valid <= 1'b1;
                    state <= S_POLL;
                end else begin
                    gcnt <= gcnt - 32'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dnn_mmap_master.sv
// tb_dnn_mmap_master: directed tests of the DNN register master against a latency-configurable slave model
module tb_dnn_mmap_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic job_valid = 1'b0;
    logic job_conv = 1'b0;
    logic [287:0] job_dims = '0;
    logic [95:0] job_offs = '0;
    logic job_ready, busy, done, err, mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0] mem_wstrb;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;
    int fin_cfg = 0;
    int inj_req = 0;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        bit          st;
        int          c;
    } txn_t;
    txn_t log_q[$];

    localparam logic [287:0] DIMS_A = {32'd1, 32'd3, 32'd8, 32'd8, 32'd3, 32'd3, 32'd4, 32'd6, 32'd6};
    localparam logic [287:0] DIMS_B = {32'd2, 32'd3, 32'd8, 32'd8, 32'd3, 32'd3, 32'd4, 32'd6, 32'd6};
    localparam logic [95:0]  OFFS_A = {32'h100, 32'h200, 32'h300};

    dnn_mmap_master #(.BASE_ADDR(32'h4000_0000), .POLL_GAP(4), .TIMEOUT(50), .TO_W(32)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_conv(job_conv),
        .job_dims(job_dims), .job_offs(job_offs), .busy(busy), .done(done), .err(err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: ready after lat+1 valid cycles; FINISH reads return fin_cfg zeros then a one
    initial begin : slave
        int wcnt, rd_cnt, inj_done, c0;
        logic [31:0] a0, d0;
        logic [3:0] s0;
        bit st;
        wcnt = 0; rd_cnt = 0; inj_done = 0; c0 = 0; st = 1'b0;
        a0 = '0; d0 = '0; s0 = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = '0;
                wcnt = 0;
            end else if (mem_valid) begin
                wcnt++;
                if (wcnt == 1) begin
                    a0 = mem_addr; d0 = mem_wdata; s0 = mem_wstrb; c0 = cyc; st = 1'b1;
                end
                st = st && mem_addr === a0 && mem_wdata === d0 && mem_wstrb === s0;
                if (wcnt > lat) begin
                    mem_ready = 1'b1;
                    log_q.push_back('{mem_addr, mem_wstrb, mem_wdata, st, c0});
                    if (mem_wstrb == 4'h0) begin
                        mem_rdata = (rd_cnt >= fin_cfg) ? 32'd1 : 32'd0;
                        rd_cnt = (rd_cnt >= fin_cfg) ? 0 : rd_cnt + 1;
                    end else if (mem_addr == 32'h4000_0038) begin
                        rd_cnt = 0;
                    end
                end
            end else begin
                wcnt = 0;
                if (inj_req != inj_done) begin
                    inj_done++;
                    mem_ready = 1'b1;
                    mem_rdata = 32'd1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_job(input logic conv, input logic [287:0] dims, input logic [95:0] offs);
        job_conv = conv; job_dims = dims; job_offs = offs; job_valid = 1'b1;
    endtask

    task automatic wait_end(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget && c < 0; i++) begin
            tick(1);
            if (done || err) c = cyc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(3); rst = 1'b0; tick(1);
        n_chk++;
        if ({mem_valid, mem_wstrb, busy, done, err} !== 8'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b addr=%h wstrb=%h wdata=%h busy=%b done=%b err=%b, want all 0",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata, busy, done, err);
        end
        n_chk++;
        if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    endtask

    task automatic test_single_job();
        logic [31:0] exp [14] = '{32'd1, 32'd1, 32'd3, 32'd8, 32'd8, 32'd3, 32'd3, 32'd4, 32'd6, 32'd6,
                                  32'h100, 32'h200, 32'h300, 32'd1};
        int b, c0, ce, nd;
        txn_t t;
        lat = 1; fin_cfg = 3; b = log_q.size();
        drive_job(1'b1, DIMS_A, OFFS_A);
        tick(1); job_valid = 1'b0; c0 = cyc;
        n_chk++;
        if (job_ready !== 1'b0 || busy !== 1'b1 || mem_valid !== 1'b1 || mem_addr !== 32'h4000_0004) begin
            n_fail++;
            $display("FAIL single_accept: ready=%b busy=%b valid=%b addr=%h, want 0 1 1 40000004",
                     job_ready, busy, mem_valid, mem_addr);
        end
        wait_end(400, ce);
        n_chk++;
        if (ce != c0 + 62 || done !== 1'b1 || err !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: cycle=%0d done=%b err=%b ready=%b busy=%b, want cycle %0d 1 0 1 0",
                     ce - c0, done, err, job_ready, busy, 62);
        end
        nd = 1;
        repeat (10) begin tick(1); if (done) nd++; end
        n_chk++;
        if (nd != 1) begin n_fail++; $display("FAIL single_done_once: got %0d pulses want 1", nd); end
        n_chk++;
        if (log_q.size() - b != 18) begin
            n_fail++; $display("FAIL single_txn_count: got %0d want 18", log_q.size() - b);
        end else begin
            for (int i = 0; i < 14; i++) begin
                t = log_q[b+i];
                n_chk++;
                if (t.a !== 32'h4000_0004 + 32'(4*i) || t.s !== 4'hF || t.d !== exp[i]) begin
                    n_fail++;
                    $display("FAIL single_write%0d: addr=%h strb=%h data=%h, want %h F %h",
                             i, t.a, t.s, t.d, 32'h4000_0004 + 32'(4*i), exp[i]);
                end
                n_chk++;
                if (t.c != c0 + 3*i || !t.st) begin
                    n_fail++;
                    $display("FAIL single_write%0d_timing: start=%0d stable=%b, want %0d 1", i, t.c - c0, t.st, 3*i);
                end
            end
            for (int j = 0; j < 4; j++) begin
                t = log_q[b+14+j];
                n_chk++;
                if (t.a !== 32'h4000_0000 || t.s !== 4'h0 || t.c != c0 + 42 + 6*j) begin
                    n_fail++;
                    $display("FAIL single_poll%0d: addr=%h strb=%h start=%0d, want 40000000 0 %0d",
                             j, t.a, t.s, t.c - c0, 42 + 6*j);
                end
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] exp [14] = '{32'd0, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13,
                                  32'hA0, 32'hB0, 32'hC0, 32'd1};
        int b, c0, ce;
        txn_t t;
        lat = 5; fin_cfg = 0; b = log_q.size();
        drive_job(1'b0, {32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13},
                  {32'hA0, 32'hB0, 32'hC0});
        tick(1); job_valid = 1'b0; c0 = cyc;
        wait_end(400, ce);
        n_chk++;
        if (ce != c0 + 104 || done !== 1'b1) begin
            n_fail++; $display("FAIL lat_done: cycle=%0d done=%b, want %0d 1", ce - c0, done, 104);
        end
        tick(3);
        n_chk++;
        if (log_q.size() - b != 15) begin
            n_fail++; $display("FAIL lat_txn_count: got %0d want 15", log_q.size() - b);
        end else begin
            for (int i = 0; i < 14; i++) begin
                t = log_q[b+i];
                n_chk++;
                if (t.a !== 32'h4000_0004 + 32'(4*i) || t.d !== exp[i] || t.s !== 4'hF || !t.st || t.c != c0 + 7*i) begin
                    n_fail++;
                    $display("FAIL lat_write%0d: addr=%h data=%h strb=%h stable=%b start=%0d, want %h %h F 1 %0d",
                             i, t.a, t.d, t.s, t.st, t.c - c0, 32'h4000_0004 + 32'(4*i), exp[i], 7*i);
                end
            end
            t = log_q[b+14];
            n_chk++;
            if (t.a !== 32'h4000_0000 || t.s !== 4'h0 || !t.st || t.c != c0 + 98) begin
                n_fail++;
                $display("FAIL lat_poll: addr=%h strb=%h stable=%b start=%0d, want 40000000 0 1 98",
                         t.a, t.s, t.st, t.c - c0);
            end
        end
    endtask

    task automatic test_timeout();
        int c0, pc, ec, ne, nd;
        lat = 1; fin_cfg = 1000000;
        drive_job(1'b1, DIMS_A, OFFS_A);
        tick(1); job_valid = 1'b0; c0 = cyc;
        pc = -1;
        for (int i = 0; i < 100 && pc < 0; i++) begin
            tick(1);
            if (mem_valid && mem_wstrb == 4'h0 && mem_addr == 32'h4000_0000) pc = cyc;
        end
        n_chk++;
        if (pc != c0 + 42) begin n_fail++; $display("FAIL to_poll_entry: got %0d want %0d", pc - c0, 42); end
        ec = -1; ne = 0; nd = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (err) begin ne++; if (ec < 0) ec = cyc; end
            if (done) nd++;
        end
        n_chk++;
        if (ne != 1 || nd != 0) begin
            n_fail++; $display("FAIL to_pulses: err=%0d done=%0d, want 1 0", ne, nd);
        end
        n_chk++;
        if (ec < pc + 49 || ec > pc + 52) begin
            n_fail++; $display("FAIL to_err_time: got %0d cycles after poll entry, want 49..52", ec - pc);
        end
        n_chk++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
            n_fail++; $display("FAIL to_idle: valid=%b busy=%b ready=%b, want 0 0 1", mem_valid, busy, job_ready);
        end
    endtask

    task automatic test_reset_mid();
        int b, b2, c0, ce, nd;
        bit found;
        lat = 1; fin_cfg = 0; b = log_q.size();
        drive_job(1'b1, DIMS_A, OFFS_A);
        tick(1); job_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (mem_valid && mem_addr == 32'h4000_001C) found = 1'b1;
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL rstmid_reach_k6: got none want addr 4000001c"); end
        rst = 1'b1; tick(1);
        n_chk++;
        if ({mem_valid, mem_wstrb, busy, done, err} !== 8'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: valid=%b addr=%h wstrb=%h wdata=%h busy=%b done=%b err=%b, want all 0",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata, busy, done, err);
        end
        rst = 1'b0; inj_req++;
        nd = 0;
        repeat (4) begin tick(1); if (done || mem_valid || busy) nd++; end
        n_chk++;
        if (nd != 0 || job_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_stray_ready: active cycles=%0d ready=%b, want 0 1", nd, job_ready);
        end
        n_chk++;
        if (log_q.size() - b != 6) begin
            n_fail++; $display("FAIL rstmid_writes_before: got %0d want 6", log_q.size() - b);
        end
        b2 = log_q.size();
        drive_job(1'b1, DIMS_A, OFFS_A);
        tick(1); job_valid = 1'b0; c0 = cyc;
        n_chk++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h4000_0004 || mem_wdata !== 32'd1) begin
            n_fail++;
            $display("FAIL rstmid_restart: valid=%b addr=%h data=%h, want 1 40000004 1", mem_valid, mem_addr, mem_wdata);
        end
        wait_end(400, ce);
        n_chk++;
        if (ce != c0 + 44 || done !== 1'b1 || log_q.size() - b2 != 15) begin
            n_fail++;
            $display("FAIL rstmid_rerun: cycle=%0d done=%b txns=%0d, want 44 1 15", ce - c0, done, log_q.size() - b2);
        end
    endtask

    task automatic test_back_to_back();
        int b, c0, c1, ce, ce2, nbad;
        lat = 1; fin_cfg = 0; b = log_q.size();
        drive_job(1'b1, DIMS_A, OFFS_A);
        tick(1); c0 = cyc;
        job_dims = DIMS_B;
        ce = -1; nbad = 0;
        for (int i = 0; i < 200 && ce < 0; i++) begin
            tick(1);
            if (done) ce = cyc;
            else if (job_ready) nbad++;
        end
        n_chk++;
        if (nbad != 0 || ce != c0 + 44) begin
            n_fail++; $display("FAIL b2b_first: ready cycles=%0d done at %0d, want 0 44", nbad, ce - c0);
        end
        tick(1); job_valid = 1'b0; c1 = cyc;
        n_chk++;
        if (c1 != ce + 1 || mem_valid !== 1'b1 || mem_addr !== 32'h4000_0004 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_accept: valid=%b addr=%h busy=%b, want 1 40000004 1", mem_valid, mem_addr, busy);
        end
        wait_end(400, ce2);
        n_chk++;
        if (ce2 != c1 + 44 || done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_done: cycle=%0d done=%b, want 44 1", ce2 - c1, done);
        end
        tick(3);
        n_chk++;
        if (log_q.size() - b != 30) begin
            n_fail++; $display("FAIL b2b_txn_count: got %0d want 30", log_q.size() - b);
        end else begin
            n_chk++;
            if (log_q[b+1].a !== 32'h4000_0008 || log_q[b+1].d !== 32'd1) begin
                n_fail++; $display("FAIL b2b_first_n: addr=%h data=%h, want 40000008 1", log_q[b+1].a, log_q[b+1].d);
            end
            n_chk++;
            if (log_q[b+16].a !== 32'h4000_0008 || log_q[b+16].d !== 32'd2 || log_q[b+15].c != c1) begin
                n_fail++;
                $display("FAIL b2b_second_n: addr=%h data=%h start=%0d, want 40000008 2 %0d",
                         log_q[b+16].a, log_q[b+16].d, log_q[b+15].c, c1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_latency();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
